main_memory: RTL and testbench

MAIN_MEMORY -- requirements
Module: main_memory

---
 rtl/main_memory_if.sv | 44 ++++
 rtl/main_memory.sv | 163 ++++++++++++++++
 tb/tb_main_memory.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_memory_if.sv
`default_nettype none
// ============================================================================
//  Module      : main_memory_if
//  Description : Block-transfer bus between the L2 cache (master) and the
//                main memory model (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface main_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int BLOCK_SIZE = 32
);
    logic [ADDR_WIDTH-1:0]                  mem_addr;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  mem_data_out;
    logic                                   mem_read;
    logic                                   mem_write;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  mem_data_block;
    logic                                   mem_ready;
    logic                                   mem_hit;
    logic                                   mem_busy;

    modport master (
        output mem_addr,
        output mem_data_out,
        output mem_read,
        output mem_write,
        input  mem_data_block,
        input  mem_ready,
        input  mem_hit,
        input  mem_busy
    );

    modport slave (
        input  mem_addr,
        input  mem_data_out,
        input  mem_read,
        input  mem_write,
        output mem_data_block,
        output mem_ready,
        output mem_hit,
        output mem_busy
    );
endinterface
`default_nettype wire

// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
//  Module      : main_memory
//  Description : Fixed-latency block memory behind the L2 cache, with one
//                valid bit per block so unwritten blocks read back as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int BLOCK_SIZE = 32,
    parameter int LATENCY    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    main_memory_if.slave       bus
);

    localparam int c_OFFSET_BITS = $clog2(BLOCK_SIZE);
    localparam int c_INDEX_BITS  = ADDR_WIDTH - c_OFFSET_BITS;
    localparam int c_NUM_BLOCKS  = 1 << c_INDEX_BITS;

    localparam logic [7:0] c_COUNT_LOAD = 8'(LATENCY - 1);

    localparam logic [1:0] c_ST_IDLE       = 2'd0;
    localparam logic [1:0] c_ST_READ_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_WRITE_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE       = 2'd3;

    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [7:0]              r_count;
    logic [7:0]              w_count_next;
    logic                    w_accept_read;
    logic                    w_accept_write;
    logic                    w_complete_read;
    logic                    w_complete_write;

    logic [c_INDEX_BITS-1:0] w_addr_index;
    logic [c_INDEX_BITS-1:0] r_index;
    block_t                  r_wdata;

    block_t                  r_storage [c_NUM_BLOCKS];
    logic [c_NUM_BLOCKS-1:0] r_valid;

    block_t                  r_data_block;
    logic                    r_ready;
    logic                    r_hit;
    logic                    r_busy;

    assign w_addr_index = bus.mem_addr[ADDR_WIDTH-1:c_OFFSET_BITS];

    // The word-offset bits select nothing: whole blocks move every transfer.
    generate
        if (c_OFFSET_BITS > 0) begin : g_offset_bits
            logic w_unused_offset;
            assign w_unused_offset = ^bus.mem_addr[c_OFFSET_BITS-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_accept_read    = 1'b0;
        w_accept_write   = 1'b0;
        w_complete_read  = 1'b0;
        w_complete_write = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                // Write wins a simultaneous request; the read is dropped.
                if (bus.mem_write) begin
                    w_accept_write = 1'b1;
                    w_count_next   = c_COUNT_LOAD;
                    w_state_next   = c_ST_WRITE_WAIT;
                end else if (bus.mem_read) begin
                    w_accept_read  = 1'b1;
                    w_count_next   = c_COUNT_LOAD;
                    w_state_next   = c_ST_READ_WAIT;
                end
            end
            c_ST_READ_WAIT: begin
                if (r_count == 8'd0) begin
                    w_complete_read = 1'b1;
                    w_state_next    = c_ST_DONE;
                end else begin
                    w_count_next    = r_count - 8'd1;
                end
            end
            c_ST_WRITE_WAIT: begin
                if (r_count == 8'd0) begin
                    w_complete_write = 1'b1;
                    w_state_next     = c_ST_DONE;
                end else begin
                    w_count_next     = r_count - 8'd1;
                end
            end
            c_ST_DONE: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_count      <= 8'd0;
            r_ready      <= 1'b0;
            r_hit        <= 1'b0;
            r_busy       <= 1'b0;
            r_data_block <= '0;
            r_valid      <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_ready <= w_complete_read | w_complete_write;
            r_hit   <= w_complete_read & r_valid[r_index];
            r_busy  <= (w_state_next != c_ST_IDLE);

            if (w_complete_read) begin
                r_data_block <= r_valid[r_index] ? r_storage[r_index] : '0;
            end
            if (w_complete_write) begin
                r_valid[r_index] <= 1'b1;
            end
        end
    end

    // Request capture: later input changes must not disturb the operation.
    always_ff @(posedge clk) begin
        if (w_accept_read || w_accept_write) begin
            r_index <= w_addr_index;
        end
        if (w_accept_write) begin
            r_wdata <= bus.mem_data_out;
        end
    end

    // Storage is not reset; a reset landing on the completion edge aborts it.
    always_ff @(posedge clk) begin
        if (!rst && w_complete_write) begin
            r_storage[r_index] <= r_wdata;
        end
    end

    assign bus.mem_data_block = r_data_block;
    assign bus.mem_ready      = r_ready;
    assign bus.mem_hit        = r_hit;
    assign bus.mem_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_main_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_memory
//  Description : Directed self-checking bench for main_memory (LATENCY 4 and 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_main_memory;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int BS = 32;
    // Negedge index (counted from the acceptance edge) at which mem_ready shows.
    localparam int EXP_K = 5;

    typedef logic [BS-1:0][DW-1:0] block_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    main_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) bus4 ();
    main_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) bus1 ();

    main_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .LATENCY(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    main_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .LATENCY(1)) u_dut_l1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    function automatic block_t make_block(input logic [31:0] base);
        block_t b;
        for (int k = 0; k < BS; k++) b[k] = base + 32'(k);
        return b;
    endfunction

    function automatic int first_diff(input block_t a, input block_t b);
        for (int k = 0; k < BS; k++) if (a[k] !== b[k]) return k;
        return -1;
    endfunction

    task automatic drive_idle();
        bus4.mem_read = 1'b0; bus4.mem_write = 1'b0;
        bus4.mem_addr = '0;   bus4.mem_data_out = '0;
        bus1.mem_read = 1'b0; bus1.mem_write = 1'b0;
        bus1.mem_addr = '0;   bus1.mem_data_out = '0;
    endtask

    // Returns the negedge index of the first mem_ready, 0 on timeout.
    task automatic wait_ready(input bit drop, input int max, output int k);
        k = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (drop && i == 1) begin
                bus4.mem_read  = 1'b0;
                bus4.mem_write = 1'b0;
            end
            if (bus4.mem_ready === 1'b1) begin
                k = i;
                return;
            end
        end
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] addr, input block_t d);
        @(negedge clk);
        bus4.mem_read = rd; bus4.mem_write = wr;
        bus4.mem_addr = addr; bus4.mem_data_out = d;
    endtask

    task automatic test_reset();
        int d;
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        checks += 5;
        if (bus4.mem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus4.mem_ready); end
        if (bus4.mem_hit !== 1'b0) begin errors++; $display("FAIL rst_hit: got %b expected 0", bus4.mem_hit); end
        if (bus4.mem_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus4.mem_busy); end
        if (bus1.mem_busy !== 1'b0) begin errors++; $display("FAIL rst_busy_l1: got %b expected 0", bus1.mem_busy); end
        d = first_diff(bus4.mem_data_block, '0);
        if (d != -1) begin errors++; $display("FAIL rst_data: word %0d got %h expected 0", d, bus4.mem_data_block[d]); end
        rst = 1'b0;
    endtask

    task automatic test_cold_read();
        int k, d;
        issue(1'b1, 1'b0, 11'h040, '0);
        wait_ready(1'b1, 20, k);
        checks += 4;
        if (k != EXP_K) begin errors++; $display("FAIL cold_latency: got %0d expected %0d", k, EXP_K); end
        if (bus4.mem_hit !== 1'b0) begin errors++; $display("FAIL cold_hit: got %b expected 0", bus4.mem_hit); end
        if (bus4.mem_busy !== 1'b1) begin errors++; $display("FAIL cold_busy_done: got %b expected 1", bus4.mem_busy); end
        d = first_diff(bus4.mem_data_block, '0);
        if (d != -1) begin errors++; $display("FAIL cold_data: word %0d got %h expected 0", d, bus4.mem_data_block[d]); end
        @(negedge clk);
        checks += 2;
        if (bus4.mem_ready !== 1'b0) begin errors++; $display("FAIL cold_pulse_width: got %b expected 0", bus4.mem_ready); end
        if (bus4.mem_busy !== 1'b0) begin errors++; $display("FAIL cold_busy_idle: got %b expected 0", bus4.mem_busy); end
    endtask

    task automatic test_write_read();
        int k, d;
        block_t a = make_block(32'hA000_0000);
        issue(1'b0, 1'b1, 11'h7E0, a);
        wait_ready(1'b1, 20, k);
        checks += 3;
        if (k != EXP_K) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", k, EXP_K); end
        if (bus4.mem_hit !== 1'b0) begin errors++; $display("FAIL wr_hit: got %b expected 0", bus4.mem_hit); end
        d = first_diff(bus4.mem_data_block, '0);
        if (d != -1) begin errors++; $display("FAIL wr_data_held: word %0d got %h expected 0", d, bus4.mem_data_block[d]); end
        @(negedge clk);
        issue(1'b1, 1'b0, 11'h7FF, '0);
        wait_ready(1'b1, 20, k);
        checks += 3;
        if (k != EXP_K) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", k, EXP_K); end
        if (bus4.mem_hit !== 1'b1) begin errors++; $display("FAIL rd_hit: got %b expected 1", bus4.mem_hit); end
        d = first_diff(bus4.mem_data_block, a);
        if (d != -1) begin errors++; $display("FAIL rd_data: word %0d got %h expected %h", d, bus4.mem_data_block[d], a[d]); end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int k, d, extra;
        block_t a = make_block(32'hA000_0000);
        block_t b = make_block(32'hB000_0000);
        issue(1'b1, 1'b1, 11'h100, b);
        wait_ready(1'b1, 20, k);
        checks += 3;
        if (k != EXP_K) begin errors++; $display("FAIL sim_latency: got %0d expected %0d", k, EXP_K); end
        if (bus4.mem_hit !== 1'b0) begin errors++; $display("FAIL sim_hit: got %b expected 0", bus4.mem_hit); end
        d = first_diff(bus4.mem_data_block, a);
        if (d != -1) begin errors++; $display("FAIL sim_data_held: word %0d got %h expected %h", d, bus4.mem_data_block[d], a[d]); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus4.mem_ready === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL sim_extra_ready: got %0d expected 0", extra); end
        issue(1'b1, 1'b0, 11'h100, '0);
        wait_ready(1'b1, 20, k);
        checks += 2;
        if (bus4.mem_hit !== 1'b1) begin errors++; $display("FAIL sim_rd_hit: got %b expected 1", bus4.mem_hit); end
        d = first_diff(bus4.mem_data_block, b);
        if (d != -1) begin errors++; $display("FAIL sim_rd_data: word %0d got %h expected %h", d, bus4.mem_data_block[d], b[d]); end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        int k, d;
        block_t a = make_block(32'hA000_0000);
        issue(1'b1, 1'b0, 11'h7E0, '0);
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus4.mem_read = 1'b0; bus4.mem_write = 1'b1;
                bus4.mem_addr = 11'h0A0; bus4.mem_data_out = make_block(32'hC000_0000);
            end else if (i == 2) begin
                bus4.mem_write = 1'b0;
            end
            if (bus4.mem_ready === 1'b1) k = i;
        end
        checks += 2;
        if (k != EXP_K) begin errors++; $display("FAIL busy_latency: got %0d expected %0d", k, EXP_K); end
        d = first_diff(bus4.mem_data_block, a);
        if (d != -1) begin errors++; $display("FAIL busy_rd_data: word %0d got %h expected %h", d, bus4.mem_data_block[d], a[d]); end
        @(negedge clk);
        issue(1'b1, 1'b0, 11'h0A0, '0);
        wait_ready(1'b1, 20, k);
        checks += 2;
        if (bus4.mem_hit !== 1'b0) begin errors++; $display("FAIL busy_ignored_hit: got %b expected 0", bus4.mem_hit); end
        d = first_diff(bus4.mem_data_block, '0);
        if (d != -1) begin errors++; $display("FAIL busy_ignored_data: word %0d got %h expected 0", d, bus4.mem_data_block[d]); end
        @(negedge clk);
    endtask

    task automatic test_held_request();
        int first, second, cnt;
        logic busy7;
        // Requester drops one cycle late: only the DONE cycle sees it.
        issue(1'b1, 1'b0, 11'h100, '0);
        first = 0; cnt = 0; busy7 = 1'bx;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (bus4.mem_ready === 1'b1) begin cnt++; if (first == 0) first = i; end
            if (i == 6) bus4.mem_read = 1'b0;
            if (i == 7) busy7 = bus4.mem_busy;
        end
        checks += 3;
        if (first != EXP_K) begin errors++; $display("FAIL held_first: got %0d expected %0d", first, EXP_K); end
        if (cnt != 1) begin errors++; $display("FAIL held_count: got %0d expected 1", cnt); end
        if (busy7 !== 1'b0) begin errors++; $display("FAIL held_busy_after: got %b expected 0", busy7); end
        // Held into IDLE: a second read is accepted right after DONE.
        issue(1'b1, 1'b0, 11'h100, '0);
        first = 0; second = 0; cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus4.mem_ready === 1'b1) begin
                cnt++;
                if (first == 0) first = i; else if (second == 0) second = i;
            end
            if (i == 11) bus4.mem_read = 1'b0;
        end
        checks += 2;
        if (second != 11) begin errors++; $display("FAIL held_second: got %0d expected 11", second); end
        if (cnt != 2) begin errors++; $display("FAIL held_again_count: got %0d expected 2", cnt); end
    endtask

    task automatic test_reset_mid_write();
        int k, d;
        logic busy3, ready3;
        issue(1'b0, 1'b1, 11'h0A0, make_block(32'hD000_0000));
        k = 0; busy3 = 1'bx; ready3 = 1'bx;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge clk);
            if (bus4.mem_ready === 1'b1) k = i;
            if (i == 1) bus4.mem_write = 1'b0;
            if (i == 2) rst = 1'b1;
            if (i == 3) begin
                busy3 = bus4.mem_busy; ready3 = bus4.mem_ready;
                rst = 1'b0; bus4.mem_read = 1'b1;
            end
            if (i == 4) bus4.mem_read = 1'b0;
        end
        checks += 4;
        if (busy3 !== 1'b0) begin errors++; $display("FAIL rstw_busy: got %b expected 0", busy3); end
        if (ready3 !== 1'b0) begin errors++; $display("FAIL rstw_ready: got %b expected 0", ready3); end
        if (k != 8) begin errors++; $display("FAIL rstw_read_after: got %0d expected 8", k); end
        if (bus4.mem_hit !== 1'b0) begin errors++; $display("FAIL rstw_hit: got %b expected 0", bus4.mem_hit); end
        d = first_diff(bus4.mem_data_block, '0);
        checks++;
        if (d != -1) begin errors++; $display("FAIL rstw_data: word %0d got %h expected 0", d, bus4.mem_data_block[d]); end
        @(negedge clk);
        issue(1'b1, 1'b0, 11'h7E0, '0);
        wait_ready(1'b1, 20, k);
        checks += 2;
        if (bus4.mem_hit !== 1'b0) begin errors++; $display("FAIL rstw_valid_cleared: got %b expected 0", bus4.mem_hit); end
        d = first_diff(bus4.mem_data_block, '0);
        if (d != -1) begin errors++; $display("FAIL rstw_old_data: word %0d got %h expected 0", d, bus4.mem_data_block[d]); end
        @(negedge clk);
    endtask

    task automatic test_latency1();
        logic [7:1] obs;
        logic       busy3;
        @(negedge clk);
        bus1.mem_read = 1'b1; bus1.mem_addr = 11'h7E0;
        obs = '0; busy3 = 1'bx;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            obs[i] = bus1.mem_ready;
            if (i == 3) busy3 = bus1.mem_busy;
            if (i == 4) bus1.mem_read = 1'b0;
        end
        checks += 2;
        if (obs !== 7'b0010010) begin errors++; $display("FAIL l1_ready_pattern: got %b expected 0010010", obs); end
        if (busy3 !== 1'b0) begin errors++; $display("FAIL l1_busy_idle: got %b expected 0", busy3); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        drive_idle();
        test_reset();
        test_cold_read();
        test_write_read();
        test_simultaneous();
        test_ignore_busy();
        test_held_request();
        test_reset_mid_write();
        test_latency1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
